// File: rtl/riscv_pkg.sv
// Shared RV32I load/store constants, LSU error codes and access size decode.
// Imported by lsu_ctrl and lsu_align.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_OK         = 2'b00,
    LSU_MISALIGNED = 2'b01,
    LSU_ILLEGAL    = 2'b10
  } lsu_err_e;

  function automatic logic [2:0] lsu_size(input logic [2:0] f3);
    logic [2:0] n;
    unique case (1'b1)
      f3[1:0] == 2'b00: n = 3'd1;
      f3[1:0] == 2'b01: n = 3'd2;
      default:          n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic f3_illegal(
    input logic       we,
    input logic [2:0] f3
  );
    logic bad;
    if (we) bad = (f3 > F3_W);
    else    bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store data shift per phase,
// load byte merge across two words, and sign/zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        phase,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] ldata
);

  logic [2:0]  nbytes;
  logic [3:0]  mask;
  logic [7:0]  be_wide;
  logic [2:0]  rem;
  logic [4:0]  sh1;
  logic [5:0]  sh2;
  logic [63:0] merged;
  logic [31:0] lo;

  always_comb begin
    nbytes  = lsu_size(funct3);
    mask    = 4'b1111;
    unique case (1'b1)
      nbytes == 3'd1: mask = 4'b0001;
      nbytes == 3'd2: mask = 4'b0011;
      default:        mask = 4'b1111;
    endcase
    be_wide = {4'b0000, mask} << off;
    rem     = 3'd4 - {1'b0, off};
    sh1     = {off, 3'b000};
    sh2     = {rem, 3'b000};
    if (phase) begin
      be       = mask >> rem;
      wdata_sh = wdata >> sh2;
    end else begin
      be       = be_wide[3:0];
      wdata_sh = wdata << sh1;
    end
    // Upper lanes of the first word followed by the low lanes of the second.
    merged = {rdata_hi, rdata_lo} >> sh1;
    lo     = merged[31:0];
    ldata  = lo;
    unique case (1'b1)
      nbytes == 3'd1:
        ldata = funct3[2] ? {24'b0, lo[7:0]}
                          : {{24{lo[7]}}, lo[7:0]};
      nbytes == 3'd2:
        ldata = funct3[2] ? {16'b0, lo[15:0]}
                          : {{16{lo[15]}}, lo[15:0]};
      default:
        ldata = lo;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit between execute and data memory: word-aligned accesses
// with byte enables, optional two-phase split, extended load data + rd tag.
module lsu_ctrl
  import riscv_pkg::*;
#(
  parameter bit SUPPORT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic [1:0]  resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic        phase_q;
  logic        split_q;
  lsu_err_e    err_q;
  logic [31:0] rlo_q;
  logic [31:0] rhi_q;

  logic        accept;
  logic [2:0]  nb_in;
  logic [3:0]  end_in;
  logic        cross_in;
  logic        misal_in;
  lsu_err_e    err_in;

  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic [31:0] ldata;
  logic [31:0] base;

  always_comb begin
    nb_in    = lsu_size(req_funct3);
    end_in   = {2'b00, req_addr[1:0]} + {1'b0, nb_in};
    cross_in = end_in > 4'd4;
    misal_in = (nb_in == 3'd2 && req_addr[0])
            || (nb_in == 3'd4 && req_addr[1:0] != 2'b00);
    err_in   = LSU_OK;
    if (f3_illegal(req_we, req_funct3))
      err_in = LSU_ILLEGAL;
    else if (misal_in && !SUPPORT_MISALIGNED)
      err_in = LSU_MISALIGNED;
  end

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept)
          state_d = (err_in != LSU_OK) ? S_RESP : S_REQ;
      S_REQ:
        if (mem_gnt) state_d = S_WAIT;
      S_WAIT:
        if (mem_rvalid)
          state_d = (!phase_q && split_q) ? S_REQ : S_RESP;
      S_RESP:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
      phase_q <= 1'b0;
      split_q <= 1'b0;
      err_q   <= LSU_OK;
      rlo_q   <= '0;
      rhi_q   <= '0;
    end else if (state_q == S_IDLE) begin
      if (accept) begin
        addr_q  <= req_addr;
        f3_q    <= req_funct3;
        we_q    <= req_we;
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
        phase_q <= 1'b0;
        split_q <= cross_in && SUPPORT_MISALIGNED
                && (err_in == LSU_OK);
        err_q   <= err_in;
        rlo_q   <= '0;
        rhi_q   <= '0;
      end
    end else if (state_q == S_WAIT && mem_rvalid) begin
      if (phase_q) rhi_q <= mem_rdata;
      else         rlo_q <= mem_rdata;
      if (!phase_q && split_q) phase_q <= 1'b1;
    end
  end

  lsu_align u_align (
    .funct3   (f3_q),
    .off      (addr_q[1:0]),
    .phase    (phase_q),
    .wdata    (wdata_q),
    .rdata_lo (rlo_q),
    .rdata_hi (rhi_q),
    .be       (be),
    .wdata_sh (wdata_sh),
    .ldata    (ldata)
  );

  assign base = {addr_q[31:2], 2'b00};

  always_comb begin
    mem_req    = (state_q == S_REQ);
    mem_we     = mem_req && we_q;
    mem_be     = mem_req ? be : 4'b0000;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (mem_req) begin
      mem_addr  = phase_q ? base + 32'd4 : base;
      mem_wdata = wdata_sh;
    end
    resp_valid = (state_q == S_RESP);
    resp_rd    = resp_valid ? rd_q : 5'd0;
    resp_err   = resp_valid ? err_q : 2'b00;
    resp_rdata = '0;
    if (resp_valid && err_q == LSU_OK && !we_q)
      resp_rdata = ldata;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a memory responder, a response scoreboard
// and an access log; a second instance covers the no-misalignment variant.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        m_req_valid = 1'b0;
  logic        m_req_ready;
  logic        m_resp_valid;
  logic [31:0] m_resp_rdata;
  logic [4:0]  m_resp_rd;
  logic [1:0]  m_resp_err;
  logic        m_mem_req;
  logic        m_mem_we;
  logic [3:0]  m_mem_be;
  logic [31:0] m_mem_addr;
  logic [31:0] m_mem_wdata;
  logic        m_mem_gnt = 1'b0;
  logic        m_mem_rvalid = 1'b0;
  logic [31:0] m_mem_rdata = '0;

  always #5 clk = ~clk;

  lsu_ctrl #(.SUPPORT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  lsu_ctrl #(.SUPPORT_MISALIGNED(1'b0)) dut_na (
    .clk(clk), .rst_n(rst_n),
    .req_valid(m_req_valid), .req_ready(m_req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .resp_valid(m_resp_valid), .resp_rdata(m_resp_rdata),
    .resp_rd(m_resp_rd), .resp_err(m_resp_err),
    .mem_req(m_mem_req), .mem_we(m_mem_we),
    .mem_be(m_mem_be), .mem_addr(m_mem_addr),
    .mem_wdata(m_mem_wdata), .mem_gnt(m_mem_gnt),
    .mem_rvalid(m_mem_rvalid), .mem_rdata(m_mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [1:0]  err;
    int          lat;
    int          t0;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } acc_t;

  exp_t        sb[$];
  acc_t        acc_q[$];
  logic [31:0] mem [0:63];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          gnt_delay = 0;
  bit          drop_rvalid = 1'b0;
  bit          m_req_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (m_mem_req) m_req_seen <= 1'b1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: optional grant delay, rvalid one cycle after gnt.
  initial begin
    bit          pend;
    logic [31:0] pdata;
    int          wcnt;
    acc_t        snap;
    logic [5:0]  idx;
    pend = 1'b0;
    pdata = '0;
    wcnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_gnt = 1'b0;
      if (!rst_n || drop_rvalid) pend = 1'b0;
      if (pend) begin
        mem_rvalid = 1'b1;
        mem_rdata = pdata;
        pend = 1'b0;
      end
      if (!rst_n) wcnt = 0;
      else if (mem_req) begin
        if (wcnt == 0) begin
          snap = '{mem_addr, mem_be, mem_we, mem_wdata};
        end else begin
          check("hold_addr", mem_addr, snap.addr);
          check("hold_be", {28'b0, mem_be}, {28'b0, snap.be});
          check("hold_wdata", mem_wdata, snap.wdata);
          check("hold_we", {31'b0, mem_we}, {31'b0, snap.we});
          check("hold_ready", {31'b0, req_ready}, 32'd0);
        end
        if (wcnt < gnt_delay) wcnt++;
        else begin
          mem_gnt = 1'b1;
          wcnt = 0;
          acc_q.push_back(snap);
          idx = snap.addr[7:2];
          if (snap.we) begin
            for (int b = 0; b < 4; b++)
              if (snap.be[b]) mem[idx][8*b +: 8] = snap.wdata[8*b +: 8];
          end else begin
            pdata = mem[idx];
          end
          pend = 1'b1;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every resp_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_resp: observed rd=%0d expected none",
                 resp_rd);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_rd", {27'b0, resp_rd}, {27'b0, e.rd});
          check("resp_err", {30'b0, resp_err}, {30'b0, e.err});
          if (e.lat >= 0)
            check("resp_latency", cyc - e.t0, e.lat);
        end
      end
    end
  end

  task automatic do_req(input logic        we,
                        input logic [2:0]  f3,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [4:0]  rd,
                        input logic [31:0] exp_rdata,
                        input logic [1:0]  exp_err,
                        input int          lat);
    exp_t e;
    @(negedge clk);
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wdata;
    req_rd = rd;
    req_valid = 1'b1;
    e = '{exp_rdata, rd, exp_err, lat, cyc};
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL resp_timeout: observed pending=%0d expected 0",
             sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_acc(input string       tag,
                         input logic [31:0] addr,
                         input logic [3:0]  be,
                         input logic        we,
                         input logic [31:0] wdata);
    acc_t a;
    checks++;
    assert (acc_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_missing: observed 0 accesses expected 1", tag);
    end
    if (acc_q.size() > 0) begin
      a = acc_q.pop_front();
      check({tag, "_addr"}, a.addr, addr);
      check({tag, "_be"}, {28'b0, a.be}, {28'b0, be});
      check({tag, "_we"}, {31'b0, a.we}, {31'b0, we});
      check({tag, "_wdata"}, a.wdata, wdata);
    end
  endtask

  task automatic chk_noacc(input string tag);
    check({tag, "_no_mem_req"}, acc_q.size(), 0);
    acc_q.delete();
  endtask

  initial begin
    #2;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1, 32'h0, 2'b00, 3);
    chk_acc("sw", 32'h10, 4'b1111, 1, 32'hDEADBEEF);
    do_req(0, 3'b010, 32'h10, 32'h0, 5'd2, 32'hDEADBEEF, 2'b00, 3);
    chk_acc("lw", 32'h10, 4'b1111, 0, 32'h0);

    do_req(1, 3'b000, 32'h9, 32'h000000AA, 5'd3, 32'h0, 2'b00, 3);
    chk_acc("sb", 32'h8, 4'b0010, 1, 32'h0000AA00);
    do_req(0, 3'b000, 32'h9, 32'h0, 5'd4, 32'hFFFFFFAA, 2'b00, 3);
    chk_acc("lb", 32'h8, 4'b0010, 0, 32'h0);
    do_req(0, 3'b100, 32'h9, 32'h0, 5'd5, 32'h000000AA, 2'b00, 3);
    chk_acc("lbu", 32'h8, 4'b0010, 0, 32'h0);

    mem[3] = 32'hBBBB0000;
    do_req(0, 3'b001, 32'd14, 32'h0, 5'd6, 32'hFFFFBBBB, 2'b00, 3);
    chk_acc("lh", 32'hC, 4'b1100, 0, 32'h0);
    do_req(0, 3'b101, 32'd14, 32'h0, 5'd7, 32'h0000BBBB, 2'b00, 3);
    chk_acc("lhu", 32'hC, 4'b1100, 0, 32'h0);

    // Misaligned SH on the no-split instance: error response, no memory.
    @(negedge clk);
    req_we = 1'b1;
    req_funct3 = 3'b001;
    req_addr = 32'd13;
    req_wdata = 32'h00001234;
    req_rd = 5'd9;
    m_req_valid = 1'b1;
    @(posedge clk);
    #1 m_req_valid = 1'b0;
    check("na_resp_valid", {31'b0, m_resp_valid}, 32'd1);
    check("na_resp_err", {30'b0, m_resp_err}, 32'd1);
    check("na_resp_rdata", m_resp_rdata, 32'd0);
    check("na_resp_rd", {27'b0, m_resp_rd}, 32'd9);
    @(posedge clk);
    #1 check("na_resp_pulse", {31'b0, m_resp_valid}, 32'd0);
    check("na_no_mem_req", {31'b0, m_req_seen}, 32'd0);

    mem[4] = 32'h11223344;
    mem[5] = 32'h55667788;
    do_req(0, 3'b010, 32'h13, 32'h0, 5'd10, 32'h66778811, 2'b00, 5);
    chk_acc("lw_split1", 32'h10, 4'b1000, 0, 32'h0);
    chk_acc("lw_split2", 32'h14, 4'b0111, 0, 32'h0);
    do_req(0, 3'b001, 32'h11, 32'h0, 5'd11, 32'h00002233, 2'b00, 3);
    chk_acc("lh_inword", 32'h10, 4'b0110, 0, 32'h0);
    mem[6] = 32'h000000F0;
    do_req(0, 3'b001, 32'h17, 32'h0, 5'd12, 32'hFFFFF055, 2'b00, 5);
    chk_acc("lh_split1", 32'h14, 4'b1000, 0, 32'h0);
    chk_acc("lh_split2", 32'h18, 4'b0001, 0, 32'h0);
    do_req(1, 3'b010, 32'h1D, 32'hA1B2C3D4, 5'd13, 32'h0, 2'b00, 5);
    chk_acc("sw_split1", 32'h1C, 4'b1110, 1, 32'hB2C3D400);
    chk_acc("sw_split2", 32'h20, 4'b0001, 1, 32'h000000A1);
    mem[63] = 32'hAABBCCDD;
    mem[0] = 32'h12345678;
    do_req(0, 3'b010, 32'hFFFFFFFE, 32'h0, 5'd14, 32'h5678AABB,
           2'b00, 5);
    chk_acc("lw_wrap1", 32'hFFFFFFFC, 4'b1100, 0, 32'h0);
    chk_acc("lw_wrap2", 32'h00000000, 4'b0011, 0, 32'h0);

    gnt_delay = 4;
    do_req(0, 3'b010, 32'h20, 32'h0, 5'd15, 32'h000000A1, 2'b00, 7);
    chk_acc("lw_slow", 32'h20, 4'b1111, 0, 32'h0);
    gnt_delay = 0;

    do_req(0, 3'b011, 32'h20, 32'h0, 5'd16, 32'h0, 2'b10, 1);
    chk_noacc("ill_load");
    do_req(1, 3'b011, 32'h20, 32'h55, 5'd17, 32'h0, 2'b10, 1);
    chk_noacc("ill_store");

    // Reset while waiting for a read completion that never arrives.
    drop_rvalid = 1'b1;
    @(negedge clk);
    req_we = 1'b0;
    req_funct3 = 3'b010;
    req_addr = 32'h40;
    req_rd = 5'd18;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 check("wait_ready", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("mid_rst_resp", {31'b0, resp_valid}, 32'd0);
    check("mid_rst_mem_be", {28'b0, mem_be}, 32'd0);
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drop_rvalid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    do_req(0, 3'b010, 32'h10, 32'h0, 5'd19, 32'h11223344, 2'b00, 3);
    chk_acc("post_rst_lw", 32'h10, 4'b1111, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
